// File: rtl/act_fetch_pkg.sv
// act_fetch_pkg: FSM encoding and tile constants shared by the activation tile fetcher
package act_fetch_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int TILE_PIX = 36;
  localparam int READ_LAT = 1;
endpackage

// File: rtl/act_tile_fetch_addr.sv
// tile_addr_gen: r/c/tx/ty counters and adder-only read address walk over overlapping tiles
module tile_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int IMG_W = 32,
  parameter int TILE = 6,
  parameter int STRIDE = 4,
  parameter int TILES_X = 7,
  parameter int TILES_Y = 7
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  input logic step,
  input logic next_tile,
  input logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic last_pix,
  output logic last_tile
);
  localparam int CW = $clog2(TILE);
  localparam int XW = $clog2(TILES_X);
  localparam int YW = $clog2(TILES_Y);
  logic [CW-1:0] r, c;
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;
  logic [ADDR_W-1:0] row_org, tile_org, band_org;
  logic last_col, last_row;
  assign last_col = c == CW'(TILE - 1);
  assign last_row = r == CW'(TILE - 1);
  assign last_pix = last_col && last_row;
  assign last_tile = tx == XW'(TILES_X - 1) && ty == YW'(TILES_Y - 1);
  assign addr = row_org + ADDR_W'(c);
  // band_org tracks the tile row origin, tile_org the tile origin, row_org the current pixel row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      c <= '0;
      tx <= '0;
      ty <= '0;
      row_org <= '0;
      tile_org <= '0;
      band_org <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
      tx <= '0;
      ty <= '0;
      row_org <= base;
      tile_org <= base;
      band_org <= base;
    end else if (next_tile) begin
      if (tx == XW'(TILES_X - 1)) begin
        tx <= '0;
        ty <= ty + YW'(1);
        band_org <= band_org + ADDR_W'(STRIDE * IMG_W);
        tile_org <= band_org + ADDR_W'(STRIDE * IMG_W);
        row_org <= band_org + ADDR_W'(STRIDE * IMG_W);
      end else begin
        tx <= tx + XW'(1);
        tile_org <= tile_org + ADDR_W'(STRIDE);
        row_org <= tile_org + ADDR_W'(STRIDE);
      end
    end else if (step) begin
      c <= last_col ? '0 : c + CW'(1);
      if (last_col) begin
        r <= last_row ? '0 : r + CW'(1);
        row_org <= last_row ? tile_org : row_org + ADDR_W'(IMG_W);
      end
    end
endmodule

// File: rtl/act_tile_fetch.sv
// act_tile_fetch: streams overlapping 6x6 activation tiles from RAM to the Winograd tile shift register.
// Define ACT_FETCH_PERF_EN to add the stall_cnt output counting unacknowledged cycles after tile_last.
module act_tile_fetch
  import act_fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int IMG_W = 32,
  parameter int TILE = 6,
  parameter int STRIDE = 4,
  parameter int TILES_X = 7,
  parameter int TILES_Y = 7
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic [ADDR_W-1:0] base_addr,
  output logic mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic out_valid,
  output logic tile_last,
  input logic tile_ack,
  output logic busy,
`ifdef ACT_FETCH_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  output logic done
);
  logic [1:0] state;
  logic [READ_LAT:0] rd_pipe, last_pipe;
  logic [ADDR_W-1:0] addr;
  logic seen, acked, elig, last_pix, last_tile;
  assign mem_rd_en = state == S_FETCH;
  assign mem_addr = mem_rd_en ? addr : '0;
  assign busy = state == S_FETCH || state == S_WAIT_ACK;
  assign done = state == S_DONE;
  assign out_valid = rd_pipe[READ_LAT];
  assign tile_last = last_pipe[READ_LAT];
  // an ack counts only once this tile's last pixel has been shifted out
  assign elig = state == S_WAIT_ACK && !acked && (tile_last || seen);
  tile_addr_gen #(
    .ADDR_W(ADDR_W), .IMG_W(IMG_W), .TILE(TILE), .STRIDE(STRIDE), .TILES_X(TILES_X), .TILES_Y(TILES_Y)
  ) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == S_IDLE && start),
    .step(mem_rd_en),
    .next_tile(state == S_WAIT_ACK && acked && !last_tile),
    .base(base_addr),
    .addr(addr),
    .last_pix(last_pix),
    .last_tile(last_tile)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      rd_pipe <= '0;
      last_pipe <= '0;
      out_data <= '0;
      seen <= 1'b0;
      acked <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[READ_LAT-1:0], mem_rd_en};
      last_pipe <= {last_pipe[READ_LAT-1:0], mem_rd_en && last_pix};
      if (rd_pipe[READ_LAT-1]) out_data <= mem_rdata;
      seen <= elig && !tile_ack;
      acked <= elig && tile_ack;
      state <= state == S_IDLE ? (start ? S_FETCH : S_IDLE)
             : state == S_FETCH ? (last_pix ? S_WAIT_ACK : S_FETCH)
             : state == S_WAIT_ACK ? (acked ? (last_tile ? S_DONE : S_FETCH) : S_WAIT_ACK)
             : S_IDLE;
    end
`ifdef ACT_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (state == S_IDLE && start) stall_cnt <= '0;
    else if (elig && !tile_ack) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_act_tile_fetch.sv
// tb_act_tile_fetch: checks act_tile_fetch against a formula-level model of the tile walk and ack handshake
module tb_act_tile_fetch;
  localparam int AW = 10, DW = 16, NT = 49, TP = 36, NR = NT * TP;
  typedef struct {int base; int tx; int ty; int r; int c; int addr;} vec_t;
  logic clk = 1'b0, rst_n, start, tile_ack;
  logic [AW-1:0] base_addr, mem_addr;
  logic [DW-1:0] mem_rdata, out_data;
  logic mem_rd_en, out_valid, tile_last, busy, done;
`ifdef ACT_FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int m_base, k, n_out, exp_rd, done_at, tiles_acked, stall_exp, start_cyc, done_cyc;
  bit m_busy, m_done, el;
  int pend_c[$], pend_d[$];
  int log_addr[NR];
  logic [575:0] result;
  vec_t vt[13];

  act_tile_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .tile_last(tile_last),
    .tile_ack(tile_ack), .busy(busy),
`ifdef ACT_FETCH_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= DW'(mem_addr);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int base, input int idx);
    int t, p;
    t = idx / TP;
    p = idx % TP;
    return (base + ((t / 7) * 4 + p / 6) * 32 + (t % 7) * 4 + p % 6) % 1024;
  endfunction

  // reference model: tiles in order, ack honoured from tile_last on, next read two cycles after it
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; k = 0; n_out = 0; exp_rd = -1; done_at = -1; el = 0; tiles_acked = 0;
      pend_c.delete(); pend_d.delete();
    end else begin
      m_done = m_busy && cyc == done_at;
      chk("done", done, m_done);
      if (done) done_cyc = cyc;
      if (m_done) m_busy = 0;
      chk("busy", busy, m_busy);
      chk("rd_en", mem_rd_en, m_busy && cyc == exp_rd);
      if (mem_rd_en) begin
        chk("rd_addr", mem_addr, exp_addr(m_base, k));
        if (k < NR) log_addr[k] = mem_addr;
        pend_c.push_back(cyc);
        pend_d.push_back(exp_addr(m_base, k));
        k++;
        exp_rd = (k % TP == 0) ? -1 : cyc + 1;
      end
      chk("out_valid", out_valid, pend_c.size() > 0 && pend_c[0] + 2 == cyc);
      if (out_valid && pend_c.size() > 0) begin
        void'(pend_c.pop_front());
        chk("out_data", out_data, pend_d.pop_front() & 16'hffff);
        chk("tile_last", tile_last, n_out % TP == TP - 1);
        if (n_out < TP) result = {result[559:0], out_data};
        if (n_out % TP == TP - 1) el = 1;
        n_out++;
      end else chk("tile_last_idle", tile_last, 0);
      if (el) begin
        if (tile_ack) begin
          el = 0;
          tiles_acked++;
          if (tiles_acked == NT) done_at = cyc + 2;
          else exp_rd = cyc + 2;
        end else stall_exp++;
      end
      if (start && !m_busy && !m_done) begin
        m_base = base_addr; k = 0; n_out = 0; exp_rd = cyc + 1; tiles_acked = 0;
        stall_exp = 0; done_at = -1; start_cyc = cyc; m_busy = 1;
      end
    end
  end

  task automatic pulse_start(input int b);
    @(posedge clk); #1 start = 1; base_addr = AW'(b);
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!done && n < budget);
    chk("done_reached", done, 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_tl();
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!tile_last && n < 200);
    chk("tile_last_seen", tile_last, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_tile_last"}, tile_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef ACT_FETCH_PERF_EN
    chk({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  task automatic check_vectors(input int b);
    for (int i = 0; i < 13; i++)
      if (vt[i].base == b)
        chk("vec_addr", log_addr[(vt[i].ty * 7 + vt[i].tx) * TP + vt[i].r * 6 + vt[i].c], vt[i].addr);
  endtask

  initial begin
    int n, ack_cyc, f_cyc;
    longint s0;
    vt[0] = '{0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 5, 5};
    vt[2] = '{0, 0, 0, 1, 0, 32};
    vt[3] = '{0, 0, 0, 5, 5, 165};
    vt[4] = '{0, 1, 0, 0, 0, 4};
    vt[5] = '{0, 0, 1, 0, 0, 128};
    vt[6] = '{0, 6, 6, 5, 5, 957};
    vt[7] = '{1000, 0, 0, 0, 0, 1000};
    vt[8] = '{1000, 0, 0, 0, 5, 1005};
    vt[9] = '{1000, 0, 0, 1, 0, 8};
    vt[10] = '{1000, 6, 0, 0, 0, 0};
    vt[11] = '{1000, 6, 0, 0, 3, 3};
    vt[12] = '{1000, 6, 6, 5, 5, 933};
    rst_n = 0; start = 0; tile_ack = 0; base_addr = '0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1;

    // pass A: ack tied high, base 0
    tile_ack = 1;
    pulse_start(0);
    wait_done(4000);
    chk("pass_len", done_cyc - start_cyc, 1912);
    chk("reads", k, NR);
    chk("busy_after", busy, 0);
    check_vectors(0);
    chk("result_first", result[575:560], 0);
    chk("result_last", result[15:0], 165);

    // pass B: 20-cycle stall, early ack, start while busy, then random acks
    tile_ack = 0;
    pulse_start(0);
    wait_tl();
`ifdef ACT_FETCH_PERF_EN
    s0 = stall_cnt;
`else
    s0 = 0;
`endif
    repeat (20) @(posedge clk);
    #1 tile_ack = 1; ack_cyc = cyc;
    @(posedge clk); #1 tile_ack = 0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!mem_rd_en && n < 10);
    chk("ack_to_fetch", cyc - ack_cyc, 2);
    chk("tile1_addr", mem_addr, 4);
`ifdef ACT_FETCH_PERF_EN
    chk("stall_hold", stall_cnt - s0, 20);
`endif
    f_cyc = cyc;
    repeat (32) @(posedge clk);
    #1 tile_ack = 1;
    @(posedge clk); #1 tile_ack = 0;
    wait_tl();
    chk("tile_last_lat", cyc - f_cyc, 37);
    repeat (4) @(posedge clk);
    #1 chk("early_ack_ignored", k, 2 * TP);
    tile_ack = 1;
    @(posedge clk); #1 tile_ack = 0;
    repeat (10) @(posedge clk);
    #1 start = 1; base_addr = AW'(500);
    @(posedge clk); #1 start = 0;
    n = 0;
    while (!done && n < 8000) begin
      @(posedge clk); #1 tile_ack = ($urandom_range(0, 3) == 0);
      n++;
    end
    chk("done_reached_rand", done, 1);
    tile_ack = 0;
    repeat (5) @(posedge clk);
    #1 chk("reads_b", k, NR);
    check_vectors(0);
`ifdef ACT_FETCH_PERF_EN
    chk("stall_total", stall_cnt, stall_exp);
`endif

    // pass C: reset while pixel 17 of tile 0 is being read
    tile_ack = 1;
    pulse_start(0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (k < 18 && n < 100);
    rst_n = 0;
    #1 check_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // pass D: base 1000 wraps modulo 1024
    pulse_start(1000);
    wait_done(4000);
    chk("pass_len_wrap", done_cyc - start_cyc, 1912);
    chk("reads_d", k, NR);
    check_vectors(1000);
`ifdef ACT_FETCH_PERF_EN
    chk("stall_clear", stall_cnt, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
